differentiator_signed_32bits: RTL and testbench
===============================================

Name: differentiator_signed_32bits

Overview:
Periodic signed first-difference block for the IMU datapath. It is the inverse of the signed periodic accumulator: every update_period+1 clocks it samples input_32 and emits the difference from the previous sample. Used to recover rate/jerk from position-like or accumulated IMU quantities. The output is registered and carries a one-cycle valid strobe for downstream consumers.

Parameters:
WIDTH, 32, data width of input_32/output_32 (block verified at 32 only)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  run control; low = hold output, restart priming
update_period  input  32  unsigned; tick when counter >= update_period (period = update_period+1 clocks)
input_32  input  32  signed two's-complement sample source
output_32  output  32  signed difference, registered
output_valid  output  1  one-cycle pulse when output_32 updates
primed  output  1  high once a reference sample is held (state RUN)

Behaviour:
- Reset (async, reset_n low): counter=0, prev_sample=0, output_32=0, output_valid=0, primed=0, state=PRIME.
- Tick generator: free-running 32-bit counter while enable=1; at counter >= update_period → tick for one cycle, counter<=0; else counter+1. update_period=0 → tick every cycle. update_period lowered below counter mid-count → tick on next cycle (>= compare).
- State PRIME: on tick, prev_sample<=input_32, state<=RUN, primed<=1; output_32 unchanged, no valid pulse.
- State RUN: on tick, output_32<=input_32 - prev_sample, prev_sample<=input_32, output_valid<=1 for exactly one cycle.
- Latency: input_32 sampled at the clock edge ending the tick cycle; output_32/output_valid visible from the following cycle.
- output_valid is 0 in every non-tick cycle.
- Arithmetic (default): 32-bit subtraction modulo 2^32 (wrap), which exactly inverts the wrapping accumulator.
- enable=0 (any time, including mid-count): counter<=0, state<=PRIME, primed<=0, output_valid<=0, output_32 and prev_sample hold. On re-enable, the first tick re-primes; no stale difference is emitted.
- enable falling in the same cycle as a tick: enable wins; no sample is taken and no valid pulse is issued.
- reset_n asserted mid-operation: all outputs return to reset values immediately (asynchronously).

Optional Feature:
DIFFERENTIATOR_SAT_EN
- Defined: the difference is computed at 33 bits and clamped to 0x7FFFFFFF / 0x80000000 on overflow.
- Undefined: plain 32-bit wrap as above. Prime/valid/timing behaviour is identical in both builds.

Decomposition:
- Package imu_diff_pkg: state encoding (PRIME, RUN), SAT_MAX=32'h7FFFFFFF, SAT_MIN=32'h80000000, WIDTH constant.
- Sub-module period_tick_gen (counter plus >= compare, enable-clear, tick output). It is natural to share with the accumulator side.

Test Plan:
- Reset then enable=1, update_period=3, input ramps +5 per tick from 100 → first tick primes (no valid); then output_32=5 with valid every 4 cycles; primed=1 after first tick.
- update_period=0, input 10,7,7,-3 on consecutive cycles → prime on cycle 1; then output_32 = -3, 0, -10 with valid high each cycle.
- Wrap build: prev=0x7FFFFFF0, input=0x80000010 → output_32=0x00000020; prev=0x80000010, input=0x7FFFFFF0 → output_32=0xFFFFFFE0.
- SAT_EN build: prev=0x80000010, input=0x7FFFFFF0 → output_32=0x7FFFFFFF; reverse case → 0x80000000.
- Drop enable mid-count (counter=2 of period 5), hold 3 cycles, re-enable → primed=0, output_32 held; next tick after 6 cycles re-primes with no valid; valid resumes on the tick after that.
- Assert reset_n mid-RUN between clock edges → output_32=0, output_valid=0, primed=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imu_diff_pkg.sv
// rtl/imu_diff_pkg.sv - shared constants and state encoding for the IMU differentiator
package imu_diff_pkg;

    localparam int WIDTH = 32;

    localparam logic [WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [WIDTH-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } diff_state_t;

endpackage

// File: rtl/period_tick_gen.sv
// rtl/period_tick_gen.sv - free-running period counter producing a one-cycle tick
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   enable         run control; low clears the counter
//   update_period  tick when counter >= update_period (period = update_period+1)
//   tick           combinational one-cycle strobe, qualified by enable
module period_tick_gen
    import imu_diff_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] update_period,
    output logic             tick
);

    logic [WIDTH-1:0] counter;

    // The >= compare (rather than ==) makes a period lowered below the
    // current count fire on the very next cycle instead of wrapping 2^32.
    assign tick = enable && (counter >= update_period);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
        end else if (!enable || tick) begin
            counter <= '0;
        end else begin
            counter <= counter + 1'b1;
        end
    end

endmodule

// File: rtl/differentiator_signed_32bits.sv
// rtl/differentiator_signed_32bits.sv - periodic signed first-difference with valid strobe
//
// Build option: DIFFERENTIATOR_SAT_EN clamps the difference to SAT_MAX/SAT_MIN
// instead of wrapping modulo 2^32.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   enable         run control; low holds output_32 and restarts priming
//   update_period  sample every update_period+1 clocks
//   input_32       signed sample source
//   output_32      registered signed difference
//   output_valid   one-cycle pulse when output_32 updates
//   primed         high once a reference sample is held
module differentiator_signed_32bits
    import imu_diff_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] update_period,
    input  logic [WIDTH-1:0] input_32,
    output logic [WIDTH-1:0] output_32,
    output logic             output_valid,
    output logic             primed
);

    logic             tick;
    diff_state_t      state;
    logic [WIDTH-1:0] prev_sample;
    logic [WIDTH-1:0] diff;

    period_tick_gen u_tick (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .update_period (update_period),
        .tick          (tick)
    );

`ifdef DIFFERENTIATOR_SAT_EN
    logic [WIDTH:0] diff_wide;

    // Sign-extend to 33 bits; the top two bits disagree exactly on overflow,
    // and bit 32 then carries the true sign of the result.
    assign diff_wide = {input_32[WIDTH-1], input_32} - {prev_sample[WIDTH-1], prev_sample};

    always_comb begin
        diff = diff_wide[WIDTH-1:0];
        if (diff_wide[WIDTH] != diff_wide[WIDTH-1]) begin
            diff = diff_wide[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    // Modulo-2^32 difference: the exact inverse of the wrapping accumulator.
    assign diff = input_32 - prev_sample;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= PRIME;
            prev_sample  <= '0;
            output_32    <= '0;
            output_valid <= 1'b0;
            primed       <= 1'b0;
        end else if (!enable) begin
            // output_32 and prev_sample hold; re-priming discards the stale reference.
            state        <= PRIME;
            output_valid <= 1'b0;
            primed       <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            if (tick) begin
                prev_sample <= input_32;
                case (state)
                    PRIME: begin
                        state  <= RUN;
                        primed <= 1'b1;
                    end
                    RUN: begin
                        output_32    <= diff;
                        output_valid <= 1'b1;
                    end
                    default: state <= PRIME;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_differentiator_signed_32bits.sv
// tb/tb_differentiator_signed_32bits.sv - self-checking bench for differentiator_signed_32bits
module tb_differentiator_signed_32bits;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [31:0] update_period;
    logic [31:0] input_32;
    logic [31:0] output_32;
    logic        output_valid;
    logic        primed;

    int n_tests;
    int n_fail;

    // Reference model state
    int unsigned m_since;   // cycles since the last sample opportunity
    bit          m_have_ref;
    logic [31:0] m_prev;
    logic [31:0] m_out;
    bit          m_valid;

    differentiator_signed_32bits dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .update_period (update_period),
        .input_32      (input_32),
        .output_32     (output_32),
        .output_valid  (output_valid),
        .primed        (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_diff(input logic [31:0] cur, input logic [31:0] prv);
        longint d;
        logic [31:0] r;
        d = longint'($signed(cur)) - longint'($signed(prv));
`ifdef DIFFERENTIATOR_SAT_EN
        if (d > 64'sd2147483647)       r = 32'h7FFF_FFFF;
        else if (d < -64'sd2147483648) r = 32'h8000_0000;
        else                           r = d[31:0];
`else
        r = d[31:0];
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_since = 0; m_have_ref = 0; m_prev = 0; m_out = 0; m_valid = 0;
    endtask

    task automatic model_step(input logic en, input logic [31:0] per, input logic [31:0] din);
        m_valid = 0;
        if (!en) begin
            m_since = 0;
            m_have_ref = 0;
        end else if (m_since >= per) begin
            m_since = 0;
            if (m_have_ref) begin
                m_out = ref_diff(din, m_prev);
                m_valid = 1;
            end
            m_have_ref = 1;
            m_prev = din;
        end else begin
            m_since++;
        end
    endtask

    task automatic run_cycle(input logic en, input logic [31:0] per, input logic [31:0] din);
        enable = en; update_period = per; input_32 = din;
        model_step(en, per, din);
        @(posedge clk); #1;
        check_eq("output_32", output_32, m_out);
        check_eq("output_valid", {31'b0, output_valid}, {31'b0, m_valid});
        check_eq("primed", {31'b0, primed}, {31'b0, m_have_ref});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] per;
        logic [31:0] din;
        logic        en;
        n_tests = 0; n_fail = 0;
        enable = 0; update_period = 0; input_32 = 0; reset_n = 1'b0;
        model_reset();
        #2;
        check_eq("reset_out", output_32, 32'h0);
        check_eq("reset_valid", {31'b0, output_valid}, 32'h0);
        check_eq("reset_primed", {31'b0, primed}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Ramp +5 per tick, period 3
        for (int i = 0; i < 16; i++) begin
            run_cycle(1'b1, 32'd3, 32'd100 + 32'd5 * (i / 4));
            if (i == 3) begin
                check_eq("ramp_prime_valid", {31'b0, output_valid}, 32'h0);
                check_eq("ramp_primed", {31'b0, primed}, 32'h1);
            end
            if (i == 7 || i == 15) begin
                check_eq("ramp_diff", output_32, 32'd5);
                check_eq("ramp_valid", {31'b0, output_valid}, 32'h1);
            end
        end

        // Period 0: 10,7,7,-3 -> -3,0,-10
        do_reset();
        run_cycle(1'b1, 32'd0, 32'd10);
        check_eq("p0_prime_valid", {31'b0, output_valid}, 32'h0);
        run_cycle(1'b1, 32'd0, 32'd7);
        check_eq("p0_d1", output_32, 32'hFFFF_FFFD);
        run_cycle(1'b1, 32'd0, 32'd7);
        check_eq("p0_d2", output_32, 32'h0);
        run_cycle(1'b1, 32'd0, 32'hFFFF_FFFD);
        check_eq("p0_d3", output_32, 32'hFFFF_FFF6);
        check_eq("p0_valid", {31'b0, output_valid}, 32'h1);

        // Overflow corners
        do_reset();
        run_cycle(1'b1, 32'd0, 32'h7FFF_FFF0);
        run_cycle(1'b1, 32'd0, 32'h8000_0010);
`ifdef DIFFERENTIATOR_SAT_EN
        check_eq("ovf_neg", output_32, 32'h8000_0000);
`else
        check_eq("ovf_neg", output_32, 32'h0000_0020);
`endif
        run_cycle(1'b1, 32'd0, 32'h7FFF_FFF0);
`ifdef DIFFERENTIATOR_SAT_EN
        check_eq("ovf_pos", output_32, 32'h7FFF_FFFF);
`else
        check_eq("ovf_pos", output_32, 32'hFFFF_FFE0);
`endif

        // Enable drop mid-count, period 5
        do_reset();
        for (int i = 0; i < 12; i++) run_cycle(1'b1, 32'd5, 32'd1000 + i);
        for (int i = 0; i < 2; i++) run_cycle(1'b1, 32'd5, 32'd2000);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'd5, 32'd3000);
        check_eq("dis_primed", {31'b0, primed}, 32'h0);
        for (int i = 0; i < 6; i++) run_cycle(1'b1, 32'd5, 32'd4000);
        check_eq("reprime_valid", {31'b0, output_valid}, 32'h0);
        check_eq("reprime_primed", {31'b0, primed}, 32'h1);
        for (int i = 0; i < 6; i++) run_cycle(1'b1, 32'd5, 32'd4100);
        check_eq("resume_diff", output_32, 32'd100);
        check_eq("resume_valid", {31'b0, output_valid}, 32'h1);

        // Asynchronous reset mid-RUN, between edges
        run_cycle(1'b1, 32'd0, 32'd50);
        run_cycle(1'b1, 32'd0, 32'd80);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_out", output_32, 32'h0);
        check_eq("async_valid", {31'b0, output_valid}, 32'h0);
        check_eq("async_primed", {31'b0, primed}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Randomized run against the model
        per = 32'd2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) per = $urandom_range(0, 6);
            en = ($urandom_range(0, 19) != 0);
            case ($urandom_range(0, 7))
                0: din = 32'h7FFF_FFFF - $urandom_range(0, 15);
                1: din = 32'h8000_0000 + $urandom_range(0, 15);
                default: din = $urandom;
            endcase
            run_cycle(en, per, din);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
